wb_byte_master: RTL and testbench
=================================

Name: wb_byte_master

Overview:
- Wishbone pipelined bus master driven by a byte stream (typically a UART RX/TX byte FIFO pair); initiator-side counterpart to the SoC's Wishbone slaves.
- Decodes single-word read/write command frames, issues one 32-bit Wishbone transaction on a crossbar master port, and returns a status/data response byte stream.
- Used as the host debug/loader path into program RAM alongside the CPU master.

Parameters:
- TIMEOUT_CYCLES, 1024: bus cycles to wait for ack/err before abort (only with WBBM_TIMEOUT_EN).
- ACK_BYTE, 8'h06: status byte for success.
- NAK_BYTE, 8'h15: status byte for bus error, timeout or unknown command.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid&rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data when tx_valid&tx_ready
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select, always 4'hF
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_stall_i  in  1  pipelined stall
- busy_o  out  1  high in any state other than CMD

Behaviour:
- Frame: cmd byte, then 4 address bytes LSB first; write frames add 4 data bytes LSB first. cmd 8'hA5 = write, 8'h5A = read.
- Response: write -> one status byte. Read -> ACK_BYTE followed by 4 data bytes LSB first, or NAK_BYTE alone.
- Reset (rst=0 at clk edge): state CMD; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_adr_o=wb_dat_o=0; wb_sel_o=4'hF; tx_valid=0; tx_data=0; rx_ready=0; byte counter=0.
  - Reset mid-transaction drops cyc/stb the next edge and discards the frame and any pending response.
- rx_ready=1 only in CMD, ADDR and DATA states; 0 elsewhere (backpressure during bus and response phases).
- FSM:
  - CMD: on accepted byte: A5 -> ADDR (we=1); 5A -> ADDR (we=0); any other value -> RESP with NAK_BYTE.
  - ADDR: collects 4 bytes into wb_adr_o[8k+7:8k], k=0..3. After the 4th: write -> DATA, read -> REQ.
  - DATA: collects 4 bytes into wb_dat_o. After the 4th -> REQ.
  - REQ: cyc=stb=1. Leave when stb&!stall at a clk edge: stb->0, go to WAIT, cyc stays 1.
    - ack/err sampled in REQ in the same cycle as acceptance are honoured: go directly to completion.
  - WAIT: cyc=1, stb=0.
    - ack -> cyc=0; capture wb_dat_i on reads; RESP with ACK_BYTE.
    - err -> cyc=0; RESP with NAK_BYTE.
    - ack and err together: err wins.
  - RESP: tx_valid=1 with status byte. On handshake: read with ACK -> RDATA; otherwise -> CMD.
  - RDATA: presents captured read data bytes 0..3 in sequence, each held until handshake. After the 4th handshake -> CMD.
- Latency: minimum 1 cycle from acceptance of the final frame byte to stb high; exactly one stb-accepted beat per frame.
- tx_data/tx_valid are registered and stable while tx_valid&!tx_ready.
- wb_adr_o and wb_dat_o are stable for the whole bus cycle.
- Byte counter is 2 bits and wraps 3->0 at each phase end.

Optional Feature:
- Macro WBBM_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to REQ and counts every cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES-1 without ack/err drops cyc/stb, goes to RESP with NAK_BYTE, and ignores any later stale ack.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: no counter; the FSM waits indefinitely in REQ/WAIT.

Decomposition:
- Package wbbm_pkg: state enum (CMD, ADDR, DATA, REQ, WAIT, RESP, RDATA), command constants CMD_WR=8'hA5 and CMD_RD=8'h5A, default ACK/NAK values.
- No sub-module required.
- Optional sub-module wbbm_shift32: LSB-first byte assembler/serializer shared by the ADDR/DATA collection and RDATA emission.

Test Plan:
- Write: bytes A5,00,00,00,04,EF,BE,AD,DE, zero-wait slave -> one beat, adr=32'h04000000, dat=32'hDEADBEEF, we=1, sel=F; tx=06.
- Read: bytes 5A,10,00,00,01; slave returns 32'h12345678 after 3 stall cycles and 2 wait cycles -> stb held 3 extra cycles, single beat; tx=06,78,56,34,12.
- Error: read with err asserted (and ack also asserted in the same cycle) -> cyc drops; tx=15 only.
- Unknown cmd 8'h00 followed by a valid write frame -> tx=15, then the write completes normally with tx=06.
- Backpressure: tx_ready low for 10 cycles during RDATA -> tx_data stable, rx_ready=0; all 5 bytes delivered in order.
- Reset asserted while in WAIT -> cyc/stb=0 the next edge, tx_valid=0. With WBBM_TIMEOUT_EN and TIMEOUT_CYCLES=16, a silent slave -> cyc drops after 16 cycles and tx=15.

Source files
------------

// File: rtl/wbbm_pkg.sv
// Shared types and constants for the Wishbone byte-stream master.
package wbbm_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DATA,
    REQ,
    WAIT,
    RESP,
    RDATA
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'hA5;
  localparam logic [7:0] CMD_RD  = 8'h5A;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/wb_byte_master.sv
// Byte-stream command decoder driving one pipelined Wishbone beat per frame.
// Optional bus timeout is enabled by defining WBBM_TIMEOUT_EN.
module wb_byte_master
  import wbbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic        busy_o
);

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic [31:0] rdata;
  logic        rd_ok;
  logic [7:0]  resp_n;
  logic        resp_ok_n;
  logic        cap_rd;
  logic        timeout_hit;
  logic        rx_fire, tx_fire;

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;
  assign wb_sel_o = 4'hF;
  assign busy_o   = (state != CMD);

`ifdef WBBM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                             tmo_cnt <= '0;
    else if (state_n == REQ && state != REQ) tmo_cnt <= '0;
    else if (state == REQ || state == WAIT)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= CMD;
    else      state <= state_n;
  end

  // Bus response checks precede the timeout so a same-cycle ack wins.
  always_comb begin
    state_n   = state;
    resp_n    = NAK_BYTE;
    resp_ok_n = 1'b0;
    cap_rd    = 1'b0;
    case (state)
      CMD:   if (rx_fire) state_n = (rx_data == CMD_WR || rx_data == CMD_RD) ? ADDR : RESP;
      ADDR:  if (rx_fire && cnt == 2'd3) state_n = wb_we_o ? DATA : REQ;
      DATA:  if (rx_fire && cnt == 2'd3) state_n = REQ;
      REQ, WAIT: begin
        if (state == REQ && wb_stall_i) begin
          if (timeout_hit) state_n = RESP;
        end else if (wb_err_i) begin
          state_n = RESP;
        end else if (wb_ack_i) begin
          state_n   = RESP;
          resp_n    = ACK_BYTE;
          resp_ok_n = 1'b1;
          cap_rd    = 1'b1;
        end else if (timeout_hit) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      RESP:  if (tx_fire) state_n = (!wb_we_o && rd_ok) ? RDATA : CMD;
      RDATA: if (tx_fire && cnt == 2'd3) state_n = CMD;
      default: state_n = CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rdata    <= '0;
      rd_ok    <= 1'b0;
      cnt      <= '0;
    end else begin
      rx_ready <= (state_n == CMD || state_n == ADDR || state_n == DATA);
      wb_cyc_o <= (state_n == REQ || state_n == WAIT);
      wb_stb_o <= (state_n == REQ);
      tx_valid <= (state_n == RESP || state_n == RDATA);
      case (state)
        CMD: if (rx_fire) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) wb_we_o <= (rx_data == CMD_WR);
          cnt <= '0;
        end
        ADDR: if (rx_fire) begin
          wb_adr_o[8*cnt +: 8] <= rx_data;
          cnt <= cnt + 2'd1;
        end
        DATA: if (rx_fire) begin
          wb_dat_o[8*cnt +: 8] <= rx_data;
          cnt <= cnt + 2'd1;
        end
        RESP: if (tx_fire) begin
          tx_data <= byte_of(rdata, 2'd0);
          cnt     <= '0;
        end
        RDATA: if (tx_fire) begin
          tx_data <= byte_of(rdata, cnt + 2'd1);
          cnt     <= cnt + 2'd1;
        end
        default: ;
      endcase
      if (cap_rd && !wb_we_o) rdata <= wb_dat_i;
      if (state_n == RESP && state != RESP) begin
        tx_data <= resp_n;
        rd_ok   <= resp_ok_n;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// Table-driven bench with a scripted Wishbone slave and tx/bus scoreboards.
module tb_wb_byte_master;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct {
    logic [71:0] frame;   // left-aligned, first byte in [71:64]
    int unsigned nbytes;
    int unsigned stall;
    int unsigned wt;
    int          kind;
    logic [31:0] rdata;
    logic [39:0] tx;      // left-aligned expected response bytes
    int unsigned ntx;
    bit          beat;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          we;
    int unsigned bp;
  } vec_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_stall_i;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_byte_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i), .busy_o(busy_o)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  int unsigned stall_left = 0, wait_left = 0, beats = 0, stb_cycles = 0, cyc_cycles = 0;
  int unsigned adr_bad = 0, txd_bad = 0, rxr_bad = 0, frame_tx = 0, bp_left = 0;
  int          cur_kind = K_ACK;
  int unsigned cur_wait = 0;
  logic [31:0] cur_rdata = '0, cur_adr = '0, cur_dat = '0;
  bit          cur_we = 1'b0;
  logic        prev_hold;
  logic [7:0]  prev_data;
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  task automatic respond();
    case (cur_kind)
      K_ACK:  begin wb_ack_i = 1'b1; wb_dat_i = cur_rdata; end
      K_ERR:  wb_err_i = 1'b1;
      K_BOTH: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = cur_rdata; end
      default: ;
    endcase
  endtask

  // Slave: decides stall/ack/err on the falling edge for the next rising edge.
  initial begin
    bus_t e;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
      if (!rst) begin
        wait_left = 0;
        continue;
      end
      if (wb_cyc_o) begin
        cyc_cycles++;
        if (wb_adr_o !== cur_adr || (cur_we && wb_dat_o !== cur_dat)) adr_bad++;
      end
      if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) respond();
      end
      if (wb_cyc_o && wb_stb_o) begin
        stb_cycles++;
        if (stall_left > 0) begin
          wb_stall_i = 1'b1;
          stall_left--;
        end else begin
          beats++;
          if (exp_bus.size() == 0) flag("unexpected bus beat");
          else begin
            e = exp_bus.pop_front();
            chk("bus adr", wb_adr_o, e.adr);
            chk("bus we", wb_we_o, e.we);
            chk("bus sel", wb_sel_o, 4'hF);
            if (e.we) chk("bus dat", wb_dat_o, e.dat);
          end
          if (cur_wait == 0) respond();
          else wait_left = cur_wait;
        end
      end
    end
  end

  // Response sink and tx scoreboard.
  initial begin
    tx_ready  = 1'b1;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tx_ready  = 1'b1;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold && tx_data !== prev_data) txd_bad++;
      tx_ready = 1'b1;
      if (tx_valid) begin
        if (rx_ready) rxr_bad++;
        if (bp_left > 0 && frame_tx >= 1) begin
          tx_ready = 1'b0;
          bp_left--;
        end else begin
          if (exp_tx.size() == 0) flag("unexpected tx byte");
          else chk("tx byte", tx_data, exp_tx.pop_front());
          frame_tx++;
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) flag("rx accept timeout");
    else @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic arm(input vec_t v);
    bus_t b;
    cur_kind = v.kind; cur_wait = v.wt; cur_rdata = v.rdata;
    cur_adr = v.adr; cur_dat = v.dat; cur_we = v.we;
    stall_left = v.stall; beats = 0; stb_cycles = 0; cyc_cycles = 0;
    adr_bad = 0; txd_bad = 0; rxr_bad = 0; frame_tx = 0; bp_left = v.bp;
    for (int unsigned i = 0; i < v.ntx; i++) exp_tx.push_back(v.tx[39-8*i -: 8]);
    if (v.beat) begin
      b.adr = v.adr; b.dat = v.dat; b.we = v.we;
      exp_bus.push_back(b);
    end
    for (int unsigned i = 0; i < v.nbytes; i++) send_byte(v.frame[71-8*i -: 8]);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int unsigned n = 0;
    arm(v);
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_tx.size() == 0 && !busy_o) && n < 3000);
    if (n >= 3000) flag({nm, " idle timeout"});
    chk({nm, " beats"}, beats, v.beat ? 1 : 0);
    chk({nm, " stb cycles"}, stb_cycles, v.beat ? v.stall + 1 : 0);
    chk({nm, " adr/dat stable"}, adr_bad, 0);
    chk({nm, " tx stable"}, txd_bad, 0);
    chk({nm, " rx_ready while tx"}, rxr_bad, 0);
    chk({nm, " tx count"}, frame_tx, v.ntx);
    chk({nm, " bus queue"}, exp_bus.size(), 0);
    chk({nm, " cyc idle"}, wb_cyc_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  vec_t rv;
  int unsigned n;

  initial begin
    rx_valid = 1'b0;
    rx_data  = '0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cyc", wb_cyc_o, 1'b0);
    chk("rst stb", wb_stb_o, 1'b0);
    chk("rst we", wb_we_o, 1'b0);
    chk("rst adr", wb_adr_o, 32'h0);
    chk("rst dat", wb_dat_o, 32'h0);
    chk("rst sel", wb_sel_o, 4'hF);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst rx_ready", rx_ready, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle rx_ready", rx_ready, 1'b1);

    tbl[0] = '{frame: 72'hA5_00_00_00_04_EF_BE_AD_DE, nbytes: 9, stall: 0, wt: 0, kind: K_ACK,
               rdata: 32'h0, tx: 40'h06_00_00_00_00, ntx: 1, beat: 1,
               adr: 32'h04000000, dat: 32'hDEADBEEF, we: 1, bp: 0};
    tbl[1] = '{frame: 72'h5A_10_00_00_01_00_00_00_00, nbytes: 5, stall: 3, wt: 2, kind: K_ACK,
               rdata: 32'h12345678, tx: 40'h06_78_56_34_12, ntx: 5, beat: 1,
               adr: 32'h01000010, dat: 32'h0, we: 0, bp: 0};
    tbl[2] = '{frame: 72'h5A_20_00_00_00_00_00_00_00, nbytes: 5, stall: 0, wt: 1, kind: K_BOTH,
               rdata: 32'hA5A5A5A5, tx: 40'h15_00_00_00_00, ntx: 1, beat: 1,
               adr: 32'h00000020, dat: 32'h0, we: 0, bp: 0};
    tbl[3] = '{frame: 72'h00_00_00_00_00_00_00_00_00, nbytes: 1, stall: 0, wt: 0, kind: K_ACK,
               rdata: 32'h0, tx: 40'h15_00_00_00_00, ntx: 1, beat: 0,
               adr: 32'h0, dat: 32'h0, we: 0, bp: 0};
    tbl[4] = '{frame: 72'hA5_00_01_00_00_44_33_22_11, nbytes: 9, stall: 1, wt: 1, kind: K_ACK,
               rdata: 32'h0, tx: 40'h06_00_00_00_00, ntx: 1, beat: 1,
               adr: 32'h00000100, dat: 32'h11223344, we: 1, bp: 0};
    tbl[5] = '{frame: 72'h5A_08_00_00_00_00_00_00_00, nbytes: 5, stall: 0, wt: 0, kind: K_ACK,
               rdata: 32'hCAFEF00D, tx: 40'h06_0D_F0_FE_CA, ntx: 5, beat: 1,
               adr: 32'h00000008, dat: 32'h0, we: 0, bp: 10};
    tbl[6] = '{frame: 72'hA5_FC_FF_FF_FF_01_00_00_00, nbytes: 9, stall: 2, wt: 0, kind: K_ERR,
               rdata: 32'h0, tx: 40'h15_00_00_00_00, ntx: 1, beat: 1,
               adr: 32'hFFFFFFFC, dat: 32'h00000001, we: 1, bp: 0};

    for (int unsigned i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while the master sits in WAIT against a silent slave.
    rv = '{frame: 72'h5A_40_00_00_00_00_00_00_00, nbytes: 5, stall: 0, wt: 0, kind: K_NONE,
           rdata: 32'h0, tx: 40'h0, ntx: 0, beat: 1,
           adr: 32'h00000040, dat: 32'h0, we: 0, bp: 0};
    arm(rv);
    n = 0;
    while (!(wb_cyc_o && !wb_stb_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach wait", {wb_cyc_o, wb_stb_o}, 2'b10);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait cyc", wb_cyc_o, 1'b0);
    chk("rstwait stb", wb_stb_o, 1'b0);
    chk("rstwait tx_valid", tx_valid, 1'b0);
    chk("rstwait busy", busy_o, 1'b0);
    chk("rstwait adr", wb_adr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait beat seen", exp_bus.size(), 0);
    chk("rstwait no tx", exp_tx.size(), 0);
    run_vec(tbl[0], "recover");

`ifdef WBBM_TIMEOUT_EN
    rv = '{frame: 72'h5A_80_00_00_00_00_00_00_00, nbytes: 5, stall: 0, wt: 0, kind: K_NONE,
           rdata: 32'h0, tx: 40'h15_00_00_00_00, ntx: 1, beat: 1,
           adr: 32'h00000080, dat: 32'h0, we: 0, bp: 0};
    run_vec(rv, "timeout");
    chk("timeout cyc cycles", cyc_cycles, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
